// File: rtl/ib_fifo.sv
// ib_fifo: show-ahead circular input buffer with occupancy pressure and sticky overflow
module ib_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3,
  parameter int DATASIZE = 40
) (
  input  logic                rc_clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] data_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic [DATASIZE-1:0] data_out,
  output logic                valid_out,
  input  logic                rc_ready,
  output logic [WIDTH:0]      pressure_out,
  output logic                overflow
);
  logic [DATASIZE-1:0] mem [DEPTH];
  logic [WIDTH-1:0] wr_ptr, rd_ptr;
  logic [WIDTH:0] count;
  logic push, pop;
  always_comb begin
    ready_out = rst_n && (count < (WIDTH+1)'(DEPTH));
    valid_out = count != '0;
    data_out = valid_out ? mem[rd_ptr] : '0;
    push = valid_in && ready_out;
    pop = valid_out && rc_ready;
    pressure_out = count;
  end
  always_ff @(posedge rc_clk)
    if (push) mem[wr_ptr] <= data_in;
  always_ff @(posedge rc_clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + WIDTH'(1);
      if (pop) rd_ptr <= rd_ptr + WIDTH'(1);
      count <= count + (WIDTH+1)'(push) - (WIDTH+1)'(pop);
      if (valid_in && !ready_out) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_ib_fifo.sv
// tb_ib_fifo: randomized and directed checks of ib_fifo against a queue model
module tb_ib_fifo;
  logic rc_clk = 0;
  logic rst_n = 0;
  logic [39:0] data_in = '0;
  logic valid_in = 0;
  logic ready_out;
  logic [39:0] data_out;
  logic valid_out;
  logic rc_ready = 0;
  logic [3:0] pressure_out;
  logic overflow;
  int tests = 0;
  int fails = 0;
  logic [39:0] q [$];
  logic ovf_m = 0;
  ib_fifo dut (
    .rc_clk(rc_clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out),
    .rc_ready(rc_ready), .pressure_out(pressure_out), .overflow(overflow)
  );
  always #5 rc_clk = ~rc_clk;
  function automatic logic [39:0] head();
    return q.size() != 0 ? q[0] : 40'd0;
  endfunction
  function automatic logic [39:0] rnd40();
    return {8'($urandom), 32'($urandom)};
  endfunction
  task automatic step(input logic v, input logic [39:0] d, input logic r, input logic rn);
    bit full, do_pop;
    valid_in = v;
    data_in = d;
    rc_ready = r;
    rst_n = rn;
    @(posedge rc_clk);
    if (!rn) begin
      q.delete();
      ovf_m = 0;
    end else begin
      full = q.size() == 8;
      do_pop = q.size() != 0 && r;
      if (v && full) ovf_m = 1;
      if (do_pop) void'(q.pop_front());
      if (v && !full) q.push_back(d);
    end
    #1;
  endtask
  task automatic do_reset();
    step(0, '0, 0, 0);
    rst_n = 1;
    #1;
  endtask
  task automatic test_reset();
    step(1, 40'hFF, 1, 0);
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b exp 0", valid_out); end
    tests++; if (data_out !== 40'd0) begin fails++; $display("FAIL reset_data got %h exp 0", data_out); end
    tests++; if (pressure_out !== 4'd0) begin fails++; $display("FAIL reset_pressure got %0d exp 0", pressure_out); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
    tests++; if (ready_out !== 1'b0) begin fails++; $display("FAIL reset_ready_low got %0b exp 0", ready_out); end
    rst_n = 1;
    #1;
    tests++; if (ready_out !== 1'b1) begin fails++; $display("FAIL reset_ready_high got %0b exp 1", ready_out); end
  endtask
  task automatic test_fill_order();
    logic [39:0] v [3];
    v[0] = 40'hA1; v[1] = 40'hA2; v[2] = 40'hA3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, v[i], 0, 1);
      tests++; if (pressure_out !== 4'(i + 1)) begin fails++; $display("FAIL fill_pressure got %0d exp %0d", pressure_out, i + 1); end
      tests++; if (data_out !== 40'hA1 || valid_out !== 1'b1) begin fails++; $display("FAIL fill_head got %h/%0b exp a1/1", data_out, valid_out); end
    end
  endtask
  task automatic test_overflow();
    logic [39:0] exp [8];
    do_reset();
    for (int i = 0; i < 8; i++) begin
      exp[i] = rnd40();
      step(1, exp[i], 0, 1);
    end
    tests++; if (ready_out !== 1'b0) begin fails++; $display("FAIL full_ready got %0b exp 0", ready_out); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL full_overflow_early got %0b exp 0", overflow); end
    step(1, 40'hDEAD, 0, 1);
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_flag got %0b exp 1", overflow); end
    tests++; if (pressure_out !== 4'd8) begin fails++; $display("FAIL overflow_pressure got %0d exp 8", pressure_out); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (data_out !== exp[i]) begin fails++; $display("FAIL drain_order[%0d] got %h exp %h", i, data_out, exp[i]); end
      step(0, '0, 1, 1);
    end
    tests++; if (valid_out !== 1'b0 || pressure_out !== 4'd0) begin fails++; $display("FAIL drain_empty got %0b/%0d exp 0/0", valid_out, pressure_out); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_sticky got %0b exp 1", overflow); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 40'(i), 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, 40'(100 + i), 1, 1);
      tests++; if (pressure_out !== 4'd4) begin fails++; $display("FAIL b2b_pressure got %0d exp 4", pressure_out); end
      tests++; if (data_out !== head()) begin fails++; $display("FAIL b2b_head got %h exp %h", data_out, head()); end
    end
  endtask
  task automatic test_empty_pop();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, '0, 1, 1);
      tests++; if (valid_out !== 1'b0 || pressure_out !== 4'd0 || data_out !== 40'd0) begin
        fails++; $display("FAIL empty_pop got %0b/%0d/%h exp 0/0/0", valid_out, pressure_out, data_out); end
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 8; i++) step(1, rnd40(), 0, 1);
    step(1, 40'h1, 0, 1);
    step(0, '0, 1, 1);
    step(0, '0, 1, 1);
    step(0, '0, 1, 1);
    tests++; if (pressure_out !== 4'd5) begin fails++; $display("FAIL mid_setup got %0d exp 5", pressure_out); end
    step(1, 40'h77, 1, 0);
    tests++; if (pressure_out !== 4'd0 || overflow !== 1'b0 || valid_out !== 1'b0) begin
      fails++; $display("FAIL mid_reset got %0d/%0b/%0b exp 0/0/0", pressure_out, overflow, valid_out); end
    step(1, 40'h5A, 0, 1);
    tests++; if (data_out !== 40'h5A || valid_out !== 1'b1) begin fails++; $display("FAIL mid_sole got %h/%0b exp 5a/1", data_out, valid_out); end
    step(0, '0, 1, 1);
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL mid_after got %0b exp 0", valid_out); end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), rnd40(), 1'($urandom_range(0, 99) < 45), 1);
      tests++; if (pressure_out !== 4'(q.size()) || pressure_out > 4'd8) begin fails++; $display("FAIL rnd_pressure got %0d exp %0d", pressure_out, q.size()); end
      tests++; if (valid_out !== (q.size() != 0) || data_out !== head()) begin fails++; $display("FAIL rnd_head got %0b/%h exp %0b/%h", valid_out, data_out, q.size() != 0, head()); end
      tests++; if (ready_out !== (q.size() < 8) || overflow !== ovf_m) begin fails++; $display("FAIL rnd_flags got %0b/%0b exp %0b/%0b", ready_out, overflow, q.size() < 8, ovf_m); end
    end
  endtask
  initial begin
    test_reset();
    test_fill_order();
    test_overflow();
    test_back_to_back();
    test_empty_pop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ib_fifo.md
IB_FIFO -- requirements
Module: ib_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning flit slots; DEPTH SHALL equal 2**WIDTH.
REQ-002 The block SHALL have parameter WIDTH, default 3, meaning pointer width; occupancy and pressure are WIDTH+1 bits.
REQ-003 The block SHALL have parameter DATASIZE, default 40, meaning flit width.
REQ-004 The block SHALL have port rc_clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  meaning reset, synchronous and active-low.
REQ-006 The block SHALL have port data_in  input  DATASIZE  meaning the flit from the link.
REQ-007 The block SHALL have port valid_in  input  1  meaning data_in carries a flit this cycle.
REQ-008 The block SHALL have port ready_out  output  1  meaning the buffer accepts a flit this cycle.
REQ-009 The block SHALL have port data_out  output  DATASIZE  meaning the head flit to route computation.
REQ-010 The block SHALL have port valid_out  output  1  meaning data_out holds a valid head flit.
REQ-011 The block SHALL have port rc_ready  input  1  meaning route computation consumes the head flit this cycle.
REQ-012 The block SHALL have port pressure_out  output  WIDTH+1  meaning current occupancy, 0..DEPTH, fed to route computation pressure inputs.
REQ-013 The block SHALL have port overflow  output  1  meaning sticky flag: a flit was offered while full.

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH x DATASIZE, with WIDTH-bit wr_ptr and rd_ptr wrapping modulo DEPTH, plus a WIDTH+1-bit count.
REQ-015 Signals: push = valid_in & ready_out; pop = valid_out & rc_ready.
REQ-016 ready_out SHALL be combinational: 1 when count < DEPTH and rst_n = 1, else 0; no pop-through when full.
REQ-017 valid_out SHALL be 1 exactly when count != 0.
REQ-018 data_out SHALL be show-ahead: mem[rd_ptr] when count != 0, all-zero when count = 0.
REQ-019 On push: mem[wr_ptr] <= data_in, wr_ptr increments, wrapping DEPTH-1 -> 0.
REQ-020 On pop: rd_ptr increments, wrapping DEPTH-1 -> 0.
REQ-021 count update: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-022 Simultaneous push and pop at 0 < count < DEPTH SHALL both take effect with count unchanged.
REQ-023 Push and pop cannot coincide when count = 0 (valid_out = 0) or count = DEPTH (ready_out = 0).
REQ-024 Latency: a flit pushed at edge N SHALL appear on data_out/valid_out after edge N when the buffer was empty; no bypass in the same cycle.
REQ-025 Flits SHALL exit in strict arrival order with no loss, duplication or reordering.
REQ-026 pressure_out SHALL equal count, updated on the same edge as count.
REQ-027 valid_in = 1 while ready_out = 0 and rst_n = 1: the flit is dropped, no state change except overflow <= 1.
REQ-028 rc_ready = 1 while valid_out = 0 SHALL have no effect; no underflow.

Reset
REQ-029 On a rising edge with rst_n = 0: wr_ptr, rd_ptr and count <= 0; overflow <= 0. Memory contents are not reset.
REQ-030 Consequently, after the reset edge: valid_out = 0, data_out = 0, pressure_out = 0, overflow = 0.
REQ-031 ready_out = 0 while rst_n = 0; ready_out = 1 in the first cycle with rst_n = 1.
REQ-032 Reset asserted mid-operation SHALL discard all stored flits, with push and pop in that cycle ignored.

Verification
REQ-033 Reset, then push 0xA1..0xA3 on consecutive cycles with rc_ready = 0 -> pressure_out 1,2,3; data_out = 0xA1, valid_out = 1 one cycle after the first push.
REQ-034 Fill 8 flits, then offer a 9th with rc_ready = 0 -> ready_out = 0, pressure_out = 8, overflow = 1; drain 8 -> original order, 9th absent.
REQ-035 At count = 4, push and pop together for 20 cycles -> pressure_out stays 4, pointers wrap, order preserved.
REQ-036 Empty buffer, rc_ready = 1 for 5 cycles -> valid_out = 0, pressure_out = 0, data_out = 0.
REQ-037 At count = 5, assert rst_n = 0 for one edge with valid_in = 1 -> count 0, overflow 0, valid_out 0; the next push is the sole flit out.
REQ-038 Random valid_in/rc_ready for 10k cycles against a scoreboard queue -> zero mismatches; pressure_out always equals queue length, in 0..8.
